// File: rtl/audio_in_deserializer.sv
// I2S ADC capture: oversampled codec pins -> stereo frames -> FIFO with valid/ready.
// Optional build macro AUDIO_IN_MONO_MIX_EN drives both outputs with the channel average.
module audio_in_deserializer #(
  parameter int         AUDIO_DATA_WIDTH = 32,
  parameter logic [4:0] BIT_COUNTER_INIT = 5'd31,
  parameter int         FIFO_DEPTH       = 8
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_ADCLRCK,
  input  logic                        AUD_ADCDAT,
  output logic                        audio_valid,
  input  logic                        audio_ready,
  output logic [AUDIO_DATA_WIDTH-1:0] data_audio_left,
  output logic [AUDIO_DATA_WIDTH-1:0] data_audio_right,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int DW = AUDIO_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  logic [2:0]      bclk_sync_q, bclk_sync_d;
  logic [1:0]      lrck_sync_q, lrck_sync_d;
  logic [1:0]      dat_sync_q, dat_sync_d;
  logic            lrck_prev_q, lrck_prev_d;
  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            word_lr_q, word_lr_d;
  logic [DW-1:0]   left_hold_q, left_hold_d;
  logic [DW-1:0]   right_hold_q, right_hold_d;
  logic            push_q, push_d;
  logic [2*DW-1:0] mem_q [FIFO_DEPTH];
  logic [2*DW-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            valid_q, valid_d;
  logic [2*DW-1:0] head_q, head_d;
  logic            overflow_q, overflow_d;

  logic            bclk_rise_s;
  logic            lrck_s;
  logic            dat_s;
  logic            lrck_edge_s;
  logic            done_s;
  logic [DW-1:0]   word_s;
  logic [5:0]      shamt_s;
  logic [2*DW-1:0] fifo_wdata_s;
  logic            full_s;
  logic            pop_s;
  logic            push_ok_s;
  logic            drop_s;

  // Pin synchronisers and BCLK-qualified edge detection
  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[0], AUD_ADCLRCK};
    dat_sync_d  = {dat_sync_q[0], AUD_ADCDAT};
    bclk_rise_s = bclk_sync_q[1] & ~bclk_sync_q[2];
    lrck_s      = lrck_sync_q[1];
    dat_s       = dat_sync_q[1];
    lrck_edge_s = bclk_rise_s & (lrck_s ^ lrck_prev_q);
    if (bclk_rise_s) begin
      lrck_prev_d = lrck_s;
    end else begin
      lrck_prev_d = lrck_prev_q;
    end
  end

  // Word-capture FSM; the BCLK rise that reveals an LRCK edge is the I2S
  // delay slot itself, so SKIP only arms the counter for one CLOCK_50 cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_lr_d = word_lr_q;
    done_s    = 1'b0;
    word_s    = '0;
    shamt_s   = {1'b0, cnt_q} + 6'd1;
    case (state_q)
      ST_SYNC: begin
        if (lrck_edge_s && !lrck_s) begin
          state_d = ST_SKIP;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_SKIP: begin
        cnt_d     = BIT_COUNTER_INIT;
        shift_d   = '0;
        word_lr_d = lrck_s;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (lrck_edge_s) begin
          // Short word: left-justify what was captured, zero-filled below.
          done_s  = 1'b1;
          word_s  = shift_q << shamt_s;
          state_d = ST_SKIP;
        end else if (bclk_rise_s) begin
          shift_d = {shift_q[DW-2:0], dat_s};
          if (cnt_q == 5'd0) begin
            done_s  = 1'b1;
            word_s  = shift_d;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (lrck_edge_s) begin
          state_d = ST_SKIP;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // Channel holding registers; a finished right word schedules the frame push
  always_comb begin
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    push_d       = 1'b0;
    if (done_s) begin
      if (!word_lr_q) begin
        left_hold_d = word_s;
      end else begin
        right_hold_d = word_s;
        push_d       = 1'b1;
      end
    end else begin
      push_d = 1'b0;
    end
  end

`ifdef AUDIO_IN_MONO_MIX_EN
  logic [DW:0]   sum_s;
  logic [DW-1:0] mix_s;
  // Signed average of both channels, carried in one extra bit
  always_comb begin
    sum_s        = {left_hold_q[DW-1], left_hold_q} + {right_hold_q[DW-1], right_hold_q};
    mix_s        = DW'(sum_s >> 1);
    fifo_wdata_s = {mix_s, mix_s};
  end
`else
  // Channels pass through unchanged
  always_comb begin
    fifo_wdata_s = {left_hold_q, right_hold_q};
  end
`endif

  // Frame FIFO with registered head; the extra pointer MSB separates full from empty
  always_comb begin
    mem_d     = mem_q;
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s     = valid_q & audio_ready;
    push_ok_s = push_q & (~full_s | pop_s);
    drop_s    = push_q & full_s & ~pop_s;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = fifo_wdata_s;
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok_s};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
    valid_d  = (wr_ptr_d != rd_ptr_d);
    if (valid_d) begin
      head_d = mem_d[rd_ptr_d[AW-1:0]];
    end else begin
      head_d = '0;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_q  <= 3'b000;
      lrck_sync_q  <= 2'b00;
      dat_sync_q   <= 2'b00;
      lrck_prev_q  <= 1'b0;
      state_q      <= ST_SYNC;
      cnt_q        <= 5'd0;
      shift_q      <= '0;
      word_lr_q    <= 1'b0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      push_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      dat_sync_q   <= dat_sync_d;
      lrck_prev_q  <= lrck_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_lr_q    <= word_lr_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      push_q       <= push_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
    end
  end

  assign audio_valid      = valid_q;
  assign data_audio_left  = head_q[2*DW-1:DW];
  assign data_audio_right = head_q[DW-1:0];
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Directed self-checking bench for audio_in_deserializer (honours AUDIO_IN_MONO_MIX_EN).
module tb_audio_in_deserializer;

  localparam int HALF_BCLK = 3;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic        audio_valid;
  logic        audio_ready;
  logic [31:0] data_audio_left;
  logic [31:0] data_audio_right;
  logic        overflow;
  logic        clear_overflow;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] rx_q[$];

  audio_in_deserializer dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .AUD_BCLK         (AUD_BCLK),
    .AUD_ADCLRCK      (AUD_ADCLRCK),
    .AUD_ADCDAT       (AUD_ADCDAT),
    .audio_valid      (audio_valid),
    .audio_ready      (audio_ready),
    .data_audio_left  (data_audio_left),
    .data_audio_right (data_audio_right),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Record every accepted frame
  always @(negedge CLOCK_50) begin
    if (audio_valid && audio_ready) begin
      rx_q.push_back({data_audio_left, data_audio_right});
    end
  end

  function automatic logic [63:0] exp_frame(input logic [31:0] l, input logic [31:0] r);
`ifdef AUDIO_IN_MONO_MIX_EN
    logic [32:0] s;
    s = {l[31], l} + {r[31], r};
    return {s[32:1], s[32:1]};
`else
    return {l, r};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    rx_q.delete();
  endtask

  task automatic send_slot(input logic lr, input logic d);
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    tick(HALF_BCLK);
    AUD_BCLK = 1'b1;
    tick(HALF_BCLK);
    AUD_BCLK = 1'b0;
  endtask

  // Delay slot, then nbits MSB-first from the left-justified word, then padding
  task automatic send_half(input logic [31:0] word, input int nbits, input int nslots, input logic lr);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < nslots; i++) begin
      if (i >= 1 && i <= nbits) begin
        send_slot(lr, w[32 - i]);
      end else begin
        send_slot(lr, 1'b0);
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits, input int nslots);
    send_half(l, nbits, nslots, 1'b0);
    send_half(r, nbits, nslots, 1'b1);
  endtask

  task automatic preamble();
    send_slot(1'b1, 1'b1);
    send_slot(1'b1, 1'b1);
  endtask

  task automatic trailer();
    send_slot(1'b0, 1'b0);
    tick(10);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(100);
    checks++;
    if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", audio_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++;
    if (data_audio_left !== 32'h0) begin errors++; $display("FAIL reset_left: got %h expected 0", data_audio_left); end
    checks++;
    if (data_audio_right !== 32'h0) begin errors++; $display("FAIL reset_right: got %h expected 0", data_audio_right); end
  endtask

  task automatic test_single_frame();
    apply_reset();
    audio_ready = 1'b1;
    preamble();
    send_frame(32'h8000_0001, 32'h7FFF_FFFE, 32, 33);
    trailer();
    checks++;
    if (rx_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
    checks++;
    if (rx_q.size() < 1 || rx_q[0] !== exp_frame(32'h8000_0001, 32'h7FFF_FFFE)) begin
      errors++;
      $display("FAIL single_data: got %h expected %h", (rx_q.size() > 0) ? rx_q[0] : 64'h0, exp_frame(32'h8000_0001, 32'h7FFF_FFFE));
    end
    checks++;
    if (audio_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %0b expected 0", audio_valid); end
  endtask

  task automatic test_mid_right_start();
    logic [63:0] exp [2];
    apply_reset();
    audio_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_slot(1'b1, 1'b1);
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 32, 33);
    send_frame(32'hCAFE_F00D, 32'h0BAD_BEEF, 32, 36);
    trailer();
    exp[0] = exp_frame(32'h1234_5678, 32'h9ABC_DEF0);
    exp[1] = exp_frame(32'hCAFE_F00D, 32'h0BAD_BEEF);
    checks++;
    if (rx_q.size() !== 2) begin errors++; $display("FAIL midright_count: got %0d expected 2", rx_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL midright_frame%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 64'h0, exp[i]);
      end
    end
  endtask

  task automatic test_24bit();
    logic [63:0] exp;
    apply_reset();
    audio_ready = 1'b1;
    preamble();
    send_frame(32'hABCD_EF00, 32'h1234_5600, 24, 25);
    trailer();
    exp = exp_frame(32'hABCD_EF00, 32'h1234_5600);
    checks++;
    if (rx_q.size() !== 1) begin errors++; $display("FAIL w24_count: got %0d expected 1", rx_q.size()); end
    checks++;
    if (rx_q.size() < 1 || rx_q[0][63:32] !== exp[63:32]) begin
      errors++;
      $display("FAIL w24_left: got %h expected %h", (rx_q.size() > 0) ? rx_q[0][63:32] : 32'h0, exp[63:32]);
    end
    checks++;
    if (rx_q.size() < 1 || rx_q[0][31:0] !== exp[31:0]) begin
      errors++;
      $display("FAIL w24_right: got %h expected %h", (rx_q.size() > 0) ? rx_q[0][31:0] : 32'h0, exp[31:0]);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
    apply_reset();
    audio_ready = 1'b0;
    preamble();
    for (int i = 0; i < 9; i++) send_frame(32'h1000_0000 + i, 32'h2000_0000 + i, 32, 33);
    trailer();
    tick(20);
    exp = exp_frame(32'h1000_0000, 32'h2000_0000);
    checks++;
    if (audio_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_full: got %0b expected 1", audio_valid); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_set: got %0b expected 1", overflow); end
    checks++;
    if ({data_audio_left, data_audio_right} !== exp) begin
      errors++;
      $display("FAIL ovf_head_hold: got %h expected %h", {data_audio_left, data_audio_right}, exp);
    end
    audio_ready = 1'b1;
    tick(12);
    audio_ready = 1'b0;
    checks++;
    if (rx_q.size() !== 8) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 8", rx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = exp_frame(32'h1000_0000 + i, 32'h2000_0000 + i);
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 64'h0, exp);
      end
    end
    checks++;
    if (audio_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_after: got %0b expected 0", audio_valid); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    tick(1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %0b expected 0", overflow); end
  endtask

  task automatic test_mono_mix();
    logic [63:0] exp;
`ifdef AUDIO_IN_MONO_MIX_EN
    exp = {32'hFFFF_FF9C, 32'hFFFF_FF9C};
`else
    exp = {32'h0000_0064, 32'hFFFF_FED4};
`endif
    apply_reset();
    audio_ready = 1'b1;
    preamble();
    send_frame(32'h0000_0064, 32'hFFFF_FED4, 32, 33);
    trailer();
    checks++;
    if (rx_q.size() !== 1) begin errors++; $display("FAIL mono_count: got %0d expected 1", rx_q.size()); end
    checks++;
    if (rx_q.size() < 1 || rx_q[0] !== exp) begin
      errors++;
      $display("FAIL mono_data: got %h expected %h", (rx_q.size() > 0) ? rx_q[0] : 64'h0, exp);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] exp [2];
    apply_reset();
    audio_ready = 1'b0;
    preamble();
    send_frame(32'h5555_AAAA, 32'hAAAA_5555, 32, 33);
    send_half(32'hFFFF_FFFF, 32, 15, 1'b0);
    checks++;
    if (audio_valid !== 1'b1) begin errors++; $display("FAIL rstmid_prefill: got %0b expected 1", audio_valid); end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    checks++;
    if (audio_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flushed: got %0b expected 0", audio_valid); end
    checks++;
    if (data_audio_left !== 32'h0) begin errors++; $display("FAIL rstmid_left_zero: got %h expected 0", data_audio_left); end
    rx_q.delete();
    audio_ready = 1'b1;
    preamble();
    send_frame(32'h0F0F_0F0F, 32'hF0F0_F0F0, 32, 33);
    send_frame(32'h0000_0001, 32'h8000_0000, 32, 33);
    trailer();
    exp[0] = exp_frame(32'h0F0F_0F0F, 32'hF0F0_F0F0);
    exp[1] = exp_frame(32'h0000_0001, 32'h8000_0000);
    checks++;
    if (rx_q.size() !== 2) begin errors++; $display("FAIL rstmid_count: got %0d expected 2", rx_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL rstmid_frame%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 64'h0, exp[i]);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    AUD_BCLK       = 1'b0;
    AUD_ADCLRCK    = 1'b0;
    AUD_ADCDAT     = 1'b0;
    audio_ready    = 1'b0;
    clear_overflow = 1'b0;
    test_reset();
    test_single_frame();
    test_mid_right_start();
    test_24bit();
    test_overflow();
    test_mono_mix();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
